// File: rtl/gcm_seq_pkg.sv
// Shared constants, state encoding and length helper for gcm_frame_sequencer.
package gcm_seq_pkg;

   localparam int unsigned NB_BLOCK        = 128;
   localparam int unsigned N_BLOCKS        = 2;
   localparam int unsigned NB_DATA         = N_BLOCKS * NB_BLOCK;
   localparam int unsigned NB_LEN          = 64;
   localparam int unsigned NB_WCNT         = 16;
   localparam int unsigned KEY_WAIT_CYCLES = 16;
   localparam int unsigned SOP_GAP         = 1;
   localparam int unsigned TIMEOUT_CYCLES  = 255;
   localparam int unsigned LEN_SHIFT       = $clog2(NB_DATA);
   localparam int unsigned NB_WAIT         = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_KEY_UPD  = 3'd1,
      ST_KEY_WAIT = 3'd2,
      ST_SOP      = 3'd3,
      ST_GAP      = 3'd4,
      ST_DATA     = 3'd5,
      ST_WAIT_TAG = 3'd6
   } state_t;

   // Plaintext length in bits: word count scaled by the data word width.
   function automatic logic [NB_LEN-1:0] frame_len_bits(input logic [NB_WCNT-1:0] words);
      return NB_LEN'(words) << LEN_SHIFT;
   endfunction

endpackage

// File: rtl/gcm_frame_sequencer.sv
// Frame/key-update sequencer in front of gcm_aes_cipher; one frame in flight at a time.
// Optional build macro GCM_SEQ_TAG_TIMEOUT_EN adds a bounded wait for the cipher tag.
module gcm_frame_sequencer
   import gcm_seq_pkg::*;
(
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic [NB_WCNT-1:0] i_req_words,
   input  logic [NB_LEN-1:0]  i_req_length_aad,
   input  logic               i_data_valid,
   output logic               o_data_ready,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_key_update_req,
   input  logic               i_cipher_tag_ready,
   input  logic               i_cipher_fault,
   output logic               o_sop,
   output logic               o_valid_text,
   output logic [NB_DATA-1:0] o_plaintext,
   output logic [NB_LEN-1:0]  o_length_plaintext,
   output logic [NB_LEN-1:0]  o_length_aad,
   output logic               o_update_key,
   output logic               o_clear_fault,
   output logic               o_busy,
   output logic               o_error
);

   state_t             state;
   logic [NB_WCNT-1:0] word_cnt;
   logic [NB_WAIT-1:0] wait_cnt;
   logic               key_pending;
   logic               key_req_any_c;
   logic               data_take_c;

   assign key_req_any_c = key_pending | i_key_update_req;
   assign data_take_c   = i_data_valid & o_data_ready;

   // Sequencer FSM; every output is produced as the value for the coming cycle.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state              <= ST_IDLE;
         word_cnt           <= '0;
         wait_cnt           <= '0;
         key_pending        <= 1'b0;
         o_req_ready        <= 1'b0;
         o_data_ready       <= 1'b0;
         o_sop              <= 1'b0;
         o_valid_text       <= 1'b0;
         o_plaintext        <= '0;
         o_length_plaintext <= '0;
         o_length_aad       <= '0;
         o_update_key       <= 1'b0;
         o_clear_fault      <= 1'b0;
         o_busy             <= 1'b0;
         o_error            <= 1'b0;
      end else begin
         o_sop         <= 1'b0;
         o_update_key  <= 1'b0;
         o_valid_text  <= 1'b0;
         o_plaintext   <= '0;
         o_req_ready   <= 1'b0;
         o_data_ready  <= 1'b0;
         o_busy        <= (state != ST_IDLE);
         o_clear_fault <= i_cipher_fault;
         o_error       <= o_error | i_cipher_fault;
         key_pending   <= key_req_any_c;

         case (state)
            ST_IDLE: begin
               // An accepted handshake wins; a key request in the same cycle stays pending.
               if (i_req_valid && o_req_ready) begin
                  state              <= ST_SOP;
                  o_sop              <= 1'b1;
                  o_busy             <= 1'b1;
                  word_cnt           <= i_req_words;
                  o_length_plaintext <= frame_len_bits(i_req_words);
                  o_length_aad       <= i_req_length_aad;
               end else if (key_req_any_c) begin
                  state        <= ST_KEY_UPD;
                  o_update_key <= 1'b1;
                  o_busy       <= 1'b1;
                  key_pending  <= 1'b0;
               end else begin
                  o_req_ready <= 1'b1;
               end
            end

            ST_KEY_UPD: begin
               state    <= ST_KEY_WAIT;
               wait_cnt <= NB_WAIT'(KEY_WAIT_CYCLES);
            end

            ST_KEY_WAIT: begin
               if (wait_cnt == NB_WAIT'(1)) begin
                  state       <= ST_IDLE;
                  o_busy      <= 1'b0;
                  o_req_ready <= !key_req_any_c;
               end else begin
                  wait_cnt <= wait_cnt - NB_WAIT'(1);
               end
            end

            ST_SOP: begin
               state    <= ST_GAP;
               wait_cnt <= NB_WAIT'(SOP_GAP);
            end

            ST_GAP: begin
               if (wait_cnt == NB_WAIT'(1)) begin
                  if (word_cnt == NB_WCNT'(0)) begin
                     state <= ST_WAIT_TAG;
`ifdef GCM_SEQ_TAG_TIMEOUT_EN
                     wait_cnt <= NB_WAIT'(TIMEOUT_CYCLES);
`endif
                  end else begin
                     state        <= ST_DATA;
                     o_data_ready <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - NB_WAIT'(1);
               end
            end

            ST_DATA: begin
               o_data_ready <= 1'b1;
               if (data_take_c) begin
                  o_valid_text <= 1'b1;
                  o_plaintext  <= i_data;
                  word_cnt     <= word_cnt - NB_WCNT'(1);
                  if (word_cnt == NB_WCNT'(1)) begin
                     state        <= ST_WAIT_TAG;
                     o_data_ready <= 1'b0;
`ifdef GCM_SEQ_TAG_TIMEOUT_EN
                     wait_cnt <= NB_WAIT'(TIMEOUT_CYCLES);
`endif
                  end
               end
            end

            ST_WAIT_TAG: begin
               if (i_cipher_tag_ready) begin
                  state       <= ST_IDLE;
                  o_busy      <= 1'b0;
                  o_req_ready <= !key_req_any_c;
               end
`ifdef GCM_SEQ_TAG_TIMEOUT_EN
               else if (wait_cnt == NB_WAIT'(1)) begin
                  state         <= ST_IDLE;
                  o_busy        <= 1'b0;
                  o_req_ready   <= !key_req_any_c;
                  o_error       <= 1'b1;
                  o_clear_fault <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - NB_WAIT'(1);
               end
`endif
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
